// File: rtl/sc_memresp_pkg.sv
// Shared types and defaults for the ARC main-memory responder: FSM states,
// request op encoding and the wait-counter width helper.
package sc_memresp_pkg;

  localparam int DEF_DATAWIDTH_BUS  = 32;
  localparam int DEF_DATAWIDTH_ADDR = 10;
  localparam int DEF_WAIT_STATES    = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Zero wait states still needs a 1-bit counter to keep the declarations legal.
  function automatic int cnt_width(input int ws);
    return (ws > 0) ? $clog2(ws + 1) : 1;
  endfunction

endpackage

// File: rtl/sc_memresp_ram.sv
// Single-port word RAM: synchronous write, registered read port that only
// updates on a read enable and clears on reset. Array contents are never reset.
module sc_memresp_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] dout_q;
  logic [DW-1:0] dout_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= din;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (re) begin
      dout_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sc_memory_responder.sv
// Multi-cycle RD/WR responder with sequencer stall; request to Ready is WAIT_STATES+1 cycles.
// Optional misalignment abort and Error_Out under SC_MEMRESP_ALIGN_CHECK_EN.
module sc_memory_responder
  import sc_memresp_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DEF_DATAWIDTH_BUS,
  parameter int DATAWIDTH_ADDR = DEF_DATAWIDTH_ADDR,
  parameter int WAIT_STATES    = DEF_WAIT_STATES
) (
  input  logic                     SC_MemResp_CLOCK_50,
  input  logic                     SC_MemResp_RESET_InLow,
  input  logic                     SC_MemResp_Read_In,
  input  logic                     SC_MemResp_Write_In,
  input  logic [DATAWIDTH_BUS-1:0] SC_MemResp_Address_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] SC_MemResp_Data_InBUS,
  output logic [DATAWIDTH_BUS-1:0] SC_MemResp_Data_OutBUS,
  output logic                     SC_MemResp_Ready_Out,
  output logic                     SC_MemResp_Stall_Out,
  output logic                     SC_MemResp_Error_Out
);

  localparam int CNT_W = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  logic clk;
  logic rst_n;
  assign clk   = SC_MemResp_CLOCK_50;
  assign rst_n = SC_MemResp_RESET_InLow;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATAWIDTH_ADDR-1:0] idx_q, idx_d;
  logic [DATAWIDTH_BUS-1:0]  wdat_q, wdat_d;
  op_e                       op_q, op_d;
  logic                      mis_q, mis_d;

  logic                      request;
  logic [DATAWIDTH_ADDR-1:0] in_idx;
  op_e                       in_op;
  logic                      in_mis;
  logic                      commit;
  logic [DATAWIDTH_ADDR-1:0] cur_idx;
  logic [DATAWIDTH_BUS-1:0]  cur_wdat;
  op_e                       cur_op;
  logic                      cur_mis;
  logic                      ram_we;
  logic                      ram_re;
  logic                      unused_addr_bits;

  assign request = SC_MemResp_Read_In | SC_MemResp_Write_In;
  assign in_idx  = SC_MemResp_Address_InBUS[DATAWIDTH_ADDR+1:2];
  // Read wins when both strobes are high; the write is simply dropped.
  assign in_op   = SC_MemResp_Read_In ? OP_READ : OP_WRITE;
`ifdef SC_MEMRESP_ALIGN_CHECK_EN
  assign in_mis  = (SC_MemResp_Address_InBUS[1:0] != 2'b00);
`else
  assign in_mis  = 1'b0;
`endif
  assign unused_addr_bits = ^{SC_MemResp_Address_InBUS[DATAWIDTH_BUS-1:DATAWIDTH_ADDR+2],
                              SC_MemResp_Address_InBUS[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      op_q    <= OP_READ;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      op_q    <= op_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    op_d    = op_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          idx_d   = in_idx;
          wdat_d  = SC_MemResp_Data_InBUS;
          op_d    = in_op;
          mis_d   = in_mis;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_STATES > 0) ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the commit edge is IDLE->DONE, before anything is latched.
  always_comb begin
    commit   = ((state_q == ST_ACCESS) && (cnt_q == '0)) ||
               ((WAIT_STATES == 0) && (state_q == ST_IDLE) && request);
    cur_idx  = (state_q == ST_IDLE) ? in_idx : idx_q;
    cur_wdat = (state_q == ST_IDLE) ? SC_MemResp_Data_InBUS : wdat_q;
    cur_op   = (state_q == ST_IDLE) ? in_op : op_q;
    cur_mis  = (state_q == ST_IDLE) ? in_mis : mis_q;
    ram_we   = rst_n & commit & (cur_op == OP_WRITE) & ~cur_mis;
    ram_re   = rst_n & commit & (cur_op == OP_READ) & ~cur_mis;
    SC_MemResp_Stall_Out = rst_n & (((state_q == ST_IDLE) & request) | (state_q == ST_ACCESS));
    SC_MemResp_Ready_Out = (state_q == ST_DONE);
`ifdef SC_MEMRESP_ALIGN_CHECK_EN
    SC_MemResp_Error_Out = (state_q == ST_DONE) & mis_q;
`else
    SC_MemResp_Error_Out = 1'b0;
`endif
  end

  sc_memresp_ram #(
    .DW (DATAWIDTH_BUS),
    .AW (DATAWIDTH_ADDR)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .idx   (cur_idx),
    .din   (cur_wdat),
    .dout  (SC_MemResp_Data_OutBUS)
  );

endmodule
